// File: rtl/plab3_mem_l2_domain_arb_pkg.sv
// plab3_mem_l2_domain_arb_pkg: FSM states, memory message widths and slot legality check
package plab3_mem_l2_domain_arb_pkg;
  typedef enum logic [1:0] {ISSUE, WAIT, PAD} state_t;
  function automatic int req_nbits(int o, int a, int d);
    return 3 + o + a + $clog2(d / 8) + d;
  endfunction
  function automatic int resp_nbits(int o, int d);
    return 3 + o + 2 + $clog2(d / 8) + d;
  endfunction
  function automatic bit slot_params_ok(int slot_len, int issue_win);
    return issue_win >= 1 && issue_win < slot_len;
  endfunction
  localparam int REQ_NBITS = req_nbits(8, 32, 128);
  localparam int RESP_NBITS = resp_nbits(8, 128);
endpackage

// File: rtl/plab3_mem_l2_domain_arb_if.sv
// plab3_mem_l2_domain_arb_if: requester-side and L2-side ports of the domain arbiter
interface plab3_mem_l2_domain_arb_if #(
  parameter int N = 2,
  parameter int REQ = plab3_mem_l2_domain_arb_pkg::REQ_NBITS,
  parameter int RESP = plab3_mem_l2_domain_arb_pkg::RESP_NBITS
);
  logic [N*REQ-1:0] in_req_msg;
  logic [N-1:0] in_req_val, in_req_rdy;
  logic [N*RESP-1:0] in_resp_msg;
  logic [N-1:0] in_resp_val, in_resp_rdy;
  logic [REQ-1:0] out_req_msg;
  logic out_req_val, out_req_rdy;
  logic [RESP-1:0] out_resp_msg;
  logic out_resp_val, out_resp_rdy;
  logic [$clog2(N)-1:0] cur_sd;
  logic overrun;
  modport slave (
    input in_req_msg, in_req_val, in_resp_rdy, out_req_rdy, out_resp_msg, out_resp_val,
    output in_req_rdy, in_resp_msg, in_resp_val, out_req_msg, out_req_val, out_resp_rdy, cur_sd, overrun
  );
  modport master (
    output in_req_msg, in_req_val, in_resp_rdy, out_req_rdy, out_resp_msg, out_resp_val,
    input in_req_rdy, in_resp_msg, in_resp_val, out_req_msg, out_req_val, out_resp_rdy, cur_sd, overrun
  );
endinterface

// File: rtl/plab3_mem_l2_slot_timer.sv
// plab3_mem_l2_slot_timer: slot cycle counter and round-robin owner with hold (stretch) and skip (early end)
module plab3_mem_l2_slot_timer #(
  parameter int p_num_reqs = 2,
  parameter int p_slot_len = 32,
  localparam int CW = $clog2(p_slot_len)
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  input  logic skip,
  output logic [$clog2(p_num_reqs)-1:0] owner,
  output logic [CW-1:0] slot_cnt,
  output logic last
);
  assign last = slot_cnt == CW'(p_slot_len - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= '0;
      slot_cnt <= '0;
    end else if (skip || (last && !hold)) begin
      owner <= owner + 1'b1;
      slot_cnt <= '0;
    end else if (!last) begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/plab3_mem_l2_domain_arb.sv
// plab3_mem_l2_domain_arb: time-division L2 port arbiter, one transaction per fixed slot per security domain
// Define PLAB3_MEM_L2_ARB_WORK_CONSERVING_EN for the higher-throughput, non-secure work-conserving variant
module plab3_mem_l2_domain_arb
  import plab3_mem_l2_domain_arb_pkg::*;
#(
  parameter int p_num_reqs = 2,
  parameter int p_opaque_nbits = 8,
  parameter int p_abw = 32,
  parameter int p_dbw = 128,
  parameter int p_slot_len = 32,
  parameter int p_issue_win = 1
) (
  input logic clk,
  input logic reset,
  plab3_mem_l2_domain_arb_if.slave bus
);
  localparam int REQ = req_nbits(p_opaque_nbits, p_abw, p_dbw);
  localparam int RESP = resp_nbits(p_opaque_nbits, p_dbw);
  localparam int OW = $clog2(p_num_reqs);
  localparam int CW = $clog2(p_slot_len);
  if (!slot_params_ok(p_slot_len, p_issue_win)) begin : g_bad_slot
    $error("p_issue_win must lie in [1, p_slot_len)");
  end
  state_t state, state_nxt;
  logic [OW-1:0] owner;
  logic [CW-1:0] slot_cnt;
  logic last, issue_ok, req_fire, resp_fire, hold, skip, adv, stretched;
  plab3_mem_l2_slot_timer #(.p_num_reqs(p_num_reqs), .p_slot_len(p_slot_len)) timer (
    .clk(clk), .reset(reset), .hold(hold), .skip(skip), .owner(owner), .slot_cnt(slot_cnt), .last(last)
  );
  assign issue_ok = state == ISSUE && slot_cnt < CW'(p_issue_win);
  assign req_fire = issue_ok && bus.in_req_val[owner] && bus.out_req_rdy;
  assign resp_fire = state == WAIT && bus.out_resp_val && bus.in_resp_rdy[owner];
  assign hold = state == WAIT && !resp_fire;
`ifdef PLAB3_MEM_L2_ARB_WORK_CONSERVING_EN
  assign skip = (state == ISSUE && slot_cnt == '0 && !bus.in_req_val[owner]) || resp_fire;
`else
  assign skip = 1'b0;
`endif
  assign adv = skip || (last && !hold);
  always_ff @(posedge clk) begin
    state <= reset ? ISSUE : state_nxt;
    stretched <= !reset && !adv && (stretched || (last && hold));
  end
  // non-owners always see rdy/val/msg at zero so no domain observes another's traffic
  always_comb begin
    state_nxt = adv ? ISSUE : req_fire ? WAIT : (resp_fire || (state == ISSUE && !issue_ok)) ? PAD : state;
    bus.in_req_rdy = '0;
    bus.in_resp_val = '0;
    bus.in_resp_msg = '0;
    bus.in_req_rdy[owner] = !reset && issue_ok && bus.out_req_rdy;
    bus.in_resp_val[owner] = !reset && state == WAIT && bus.out_resp_val;
    bus.in_resp_msg[RESP*int'(owner) +: RESP] = state == WAIT ? bus.out_resp_msg : '0;
  end
  assign bus.out_req_val = !reset && issue_ok && bus.in_req_val[owner];
  assign bus.out_req_msg = bus.in_req_msg[REQ*int'(owner) +: REQ];
  assign bus.out_resp_rdy = !reset && state == WAIT && bus.in_resp_rdy[owner];
  assign bus.cur_sd = owner;
  assign bus.overrun = !reset && last && hold && !stretched;
endmodule
